pic_bus_sequencer: RTL and testbench

Clocked, parametrised bus front-end for the 8259A-style PIC. It synchronises CS_bar/RD_bar/WR_bar and commits each completed write as exactly one command word. An initialisation state machine tracks the ICW1→ICW2→(ICW3)→(ICW4) sequence and holds the programmed ICW/OCW registers. It also drives the read-back mux (IRR/ISR/IMR/poll word). It sits between the external CPU pins and the priority-resolver and cascade logic, which consume its registers and single-cycle strobes.

---
 rtl/pic_bus_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_pic_bus_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pic_bus_sequencer.sv
// pic_bus_sequencer: CPU bus front-end for an 8259A-style PIC.
// Synchronises the CPU strobes and commits each completed write as one
// command word. Tracks the ICW1..ICW4 initialisation sequence, holds the
// programmed ICW/OCW registers and drives the read-back mux.
module pic_bus_sequencer #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_bar,
  input  logic                  CS_bar,
  input  logic                  RD_bar,
  input  logic                  WR_bar,
  input  logic                  A0,
  input  logic [DATA_WIDTH-1:0] data_bus_in,
  output logic [DATA_WIDTH-1:0] data_bus_out,
  output logic                  data_bus_oe,
  input  logic [DATA_WIDTH-1:0] irr_in,
  input  logic [DATA_WIDTH-1:0] isr_in,
  input  logic [7:0]            poll_word_in,
  output logic [6:0]            cw_strobe,
  output logic [7:0]            icw1_q,
  output logic [7:0]            icw2_q,
  output logic [DATA_WIDTH-1:0] icw3_q,
  output logic [7:0]            icw4_q,
  output logic [7:0]            ocw2_q,
  output logic [DATA_WIDTH-1:0] imr_q,
  output logic                  rd_sel_q,
  output logic                  smm_q,
  output logic                  poll_q,
  output logic                  init_done,
  output logic                  read_done
);

  localparam int MSB = SYNC_STAGES - 1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ICW2,
    WAIT_ICW3,
    WAIT_ICW4,
    READY
  } state_t;

  state_t state_q, state_d;

  // Strobe pins idle high, so the synchronisers reset to all ones.
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] rd_sync_q, rd_sync_d;
  logic [SYNC_STAGES-1:0] wr_sync_q, wr_sync_d;

  logic                  wr_act, rd_act, wr_fall, rd_fall;
  logic                  wr_act_q, wr_act_d, rd_act_q, rd_act_d;
  logic                  a0_cap_q, a0_cap_d;
  logic [DATA_WIDTH-1:0] data_cap_q, data_cap_d;
  logic [7:0]            cmd;

  logic [7:0]            icw1_d, icw2_d, icw4_d, ocw2_d;
  logic [DATA_WIDTH-1:0] icw3_d, imr_d;
  logic                  rd_sel_d, smm_d, poll_d;
  logic [6:0]            cw_strobe_q, cw_strobe_d;
  logic                  read_done_q, read_done_d;

  assign wr_act  = ~wr_sync_q[MSB] & ~cs_sync_q[MSB];
  assign rd_act  = ~rd_sync_q[MSB] & ~cs_sync_q[MSB];
  assign wr_fall = wr_act_q & ~wr_act;
  assign rd_fall = rd_act_q & ~rd_act;
  assign cmd     = data_cap_q[7:0];

  assign cw_strobe = cw_strobe_q;
  assign read_done = read_done_q;
  assign init_done = (state_q == READY);

  // Initialisation state register.
  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Synchronisers, write capture, commit decode and next-state logic.
  always_comb begin
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], CS_bar};
    rd_sync_d   = {rd_sync_q[SYNC_STAGES-2:0], RD_bar};
    wr_sync_d   = {wr_sync_q[SYNC_STAGES-2:0], WR_bar};
    wr_act_d    = wr_act;
    rd_act_d    = rd_act;
    a0_cap_d    = wr_act ? A0 : a0_cap_q;
    data_cap_d  = wr_act ? data_bus_in : data_cap_q;
    state_d     = state_q;
    icw1_d      = icw1_q;
    icw2_d      = icw2_q;
    icw3_d      = icw3_q;
    icw4_d      = icw4_q;
    ocw2_d      = ocw2_q;
    imr_d       = imr_q;
    rd_sel_d    = rd_sel_q;
    smm_d       = smm_q;
    poll_d      = poll_q;
    cw_strobe_d = 7'd0;
    read_done_d = rd_fall;

    // The poll clear comes first so that an OCW3 poll set in the same
    // cycle overrides it.
    if (rd_fall) poll_d = 1'b0;

    if (wr_fall) begin
      if (!a0_cap_q && cmd[4]) begin
        icw1_d      = cmd;
        icw2_d      = 8'd0;
        icw3_d      = '0;
        icw4_d      = 8'd0;
        ocw2_d      = 8'd0;
        imr_d       = '0;
        rd_sel_d    = 1'b0;
        smm_d       = 1'b0;
        poll_d      = 1'b0;
        cw_strobe_d = 7'b000_0001;
        state_d     = WAIT_ICW2;
      end else begin
        case (state_q)
          WAIT_ICW2: if (a0_cap_q) begin
            icw2_d      = cmd;
            cw_strobe_d = 7'b000_0010;
            if (!icw1_q[1])     state_d = WAIT_ICW3;
            else if (icw1_q[0]) state_d = WAIT_ICW4;
            else                state_d = READY;
          end
          WAIT_ICW3: if (a0_cap_q) begin
            icw3_d      = data_cap_q;
            cw_strobe_d = 7'b000_0100;
            state_d     = icw1_q[0] ? WAIT_ICW4 : READY;
          end
          WAIT_ICW4: if (a0_cap_q) begin
            icw4_d      = cmd;
            cw_strobe_d = 7'b000_1000;
            state_d     = READY;
          end
          READY: begin
            if (a0_cap_q) begin
              imr_d       = data_cap_q;
              cw_strobe_d = 7'b001_0000;
            end else if (!cmd[3]) begin
              ocw2_d      = cmd;
              cw_strobe_d = 7'b010_0000;
            end else begin
              cw_strobe_d = 7'b100_0000;
              if (cmd[1]) rd_sel_d = cmd[0];
              if (cmd[6]) smm_d    = cmd[5];
              if (cmd[2]) poll_d   = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Datapath and command register flops.
  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) begin
      cs_sync_q   <= '1;
      rd_sync_q   <= '1;
      wr_sync_q   <= '1;
      wr_act_q    <= 1'b0;
      rd_act_q    <= 1'b0;
      a0_cap_q    <= 1'b0;
      data_cap_q  <= '0;
      icw1_q      <= 8'd0;
      icw2_q      <= 8'd0;
      icw3_q      <= '0;
      icw4_q      <= 8'd0;
      ocw2_q      <= 8'd0;
      imr_q       <= '1;
      rd_sel_q    <= 1'b0;
      smm_q       <= 1'b0;
      poll_q      <= 1'b0;
      cw_strobe_q <= 7'd0;
      read_done_q <= 1'b0;
    end else begin
      cs_sync_q   <= cs_sync_d;
      rd_sync_q   <= rd_sync_d;
      wr_sync_q   <= wr_sync_d;
      wr_act_q    <= wr_act_d;
      rd_act_q    <= rd_act_d;
      a0_cap_q    <= a0_cap_d;
      data_cap_q  <= data_cap_d;
      icw1_q      <= icw1_d;
      icw2_q      <= icw2_d;
      icw3_q      <= icw3_d;
      icw4_q      <= icw4_d;
      ocw2_q      <= ocw2_d;
      imr_q       <= imr_d;
      rd_sel_q    <= rd_sel_d;
      smm_q       <= smm_d;
      poll_q      <= poll_d;
      cw_strobe_q <= cw_strobe_d;
      read_done_q <= read_done_d;
    end
  end

  // Read-back path: enable straight from the pins, a write always wins.
  always_comb begin
    data_bus_oe  = ~RD_bar & ~CS_bar & WR_bar;
    data_bus_out = irr_in;
    if (poll_q) begin
      data_bus_out       = '0;
      data_bus_out[7:0]  = poll_word_in;
    end else if (A0) begin
      data_bus_out = imr_q;
    end else if (rd_sel_q) begin
      data_bus_out = isr_in;
    end
  end

endmodule

// File: tb/tb_pic_bus_sequencer.sv
// tb_pic_bus_sequencer: directed bench with a scoreboard. Stimulus tasks
// push hand-computed expectations; a monitor pops and compares them
// whenever the DUT strobes a commit, enables the read bus or pulses
// read_done.
module tb_pic_bus_sequencer;

  localparam int R_NONE  = 0;
  localparam int R_ICW1  = 1;
  localparam int R_ICW2  = 2;
  localparam int R_ICW3  = 3;
  localparam int R_ICW4  = 4;
  localparam int R_IMR   = 5;
  localparam int R_OCW2  = 6;
  localparam int R_RDSEL = 7;
  localparam int R_SMM   = 8;
  localparam int R_POLL  = 9;
  localparam int R_INIT  = 10;

  logic       clk = 1'b0;
  logic       rst_bar;
  logic       CS_bar, RD_bar, WR_bar, A0;
  logic [7:0] dataIn, dataOut;
  logic       oe;
  logic [7:0] irrIn, isrIn, pollWord;
  logic [6:0] cwStrobe;
  logic [7:0] icw1, icw2, icw3, icw4, ocw2, imr;
  logic       rdSel, smm, poll, initDone, readDone;

  int cycleCnt    = 0;
  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct {
    logic [6:0] strobe;
    int         due;
    int         regA;
    logic [7:0] valA;
    int         regB;
    logic [7:0] valB;
  } cmdExp_t;

  cmdExp_t    cmdQ[$];
  logic [7:0] readQ[$];
  int         doneQ[$];

  pic_bus_sequencer #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_bar(rst_bar), .CS_bar(CS_bar), .RD_bar(RD_bar),
    .WR_bar(WR_bar), .A0(A0), .data_bus_in(dataIn), .data_bus_out(dataOut),
    .data_bus_oe(oe), .irr_in(irrIn), .isr_in(isrIn),
    .poll_word_in(pollWord), .cw_strobe(cwStrobe), .icw1_q(icw1),
    .icw2_q(icw2), .icw3_q(icw3), .icw4_q(icw4), .ocw2_q(ocw2),
    .imr_q(imr), .rd_sel_q(rdSel), .smm_q(smm), .poll_q(poll),
    .init_done(initDone), .read_done(readDone)
  );

  // Free-running clock and cycle counter used for latency checks.
  always #5 clk = ~clk;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  function automatic logic [7:0] getReg(int id);
    case (id)
      R_ICW1:  return icw1;
      R_ICW2:  return icw2;
      R_ICW3:  return icw3;
      R_ICW4:  return icw4;
      R_IMR:   return imr;
      R_OCW2:  return ocw2;
      R_RDSEL: return {7'd0, rdSel};
      R_SMM:   return {7'd0, smm};
      R_POLL:  return {7'd0, poll};
      R_INIT:  return {7'd0, initDone};
      default: return 8'd0;
    endcase
  endfunction

  task automatic checkOutput(string name, logic [7:0] actual, logic [7:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, actual, expected);
    end
  endtask

  task automatic checkCycle(string name, int actual, int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic waitCycles(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One CPU write. mode 0: normal, 1: CS_bar rises a cycle before WR_bar,
  // 2: RD_bar held low alongside WR_bar.
  task automatic applyStimulus(input logic a0v, input logic [7:0] d, input int mode,
                               input logic [6:0] expStrobe, input int ra, input logic [7:0] va,
                               input int rb, input logic [7:0] vb);
    cmdExp_t e;
    int      due;
    A0     = a0v;
    dataIn = d;
    CS_bar = 1'b0;
    WR_bar = 1'b0;
    if (mode == 2) RD_bar = 1'b0;
    waitCycles(1);
    if (mode == 2) checkOutput("oe_both_low", {7'd0, oe}, 8'd0);
    waitCycles(3);
    due = cycleCnt + 3;
    e.strobe = expStrobe; e.due = due;
    e.regA = ra; e.valA = va; e.regB = rb; e.valB = vb;
    if (expStrobe != 7'd0) cmdQ.push_back(e);
    if (mode == 2) doneQ.push_back(due);
    if (mode == 1) begin
      CS_bar = 1'b1;
      waitCycles(1);
      WR_bar = 1'b1;
    end else begin
      WR_bar = 1'b1;
      CS_bar = 1'b1;
      RD_bar = 1'b1;
    end
    waitCycles(5);
  endtask

  // One CPU read with the expected read-back data.
  task automatic applyRead(input logic a0v, input logic [7:0] expData);
    A0 = a0v;
    readQ.push_back(expData);
    CS_bar = 1'b0;
    RD_bar = 1'b0;
    waitCycles(4);
    doneQ.push_back(cycleCnt + 3);
    RD_bar = 1'b1;
    CS_bar = 1'b1;
    waitCycles(5);
  endtask

  // Monitor: compares DUT events against the scoreboard queues.
  initial begin
    cmdExp_t e;
    logic    oePrev;
    oePrev = 1'b0;
    forever begin
      @(negedge clk);
      if (cwStrobe != 7'd0) begin
        if (cmdQ.size() == 0) begin
          checkOutput("unexpected_strobe", {1'b0, cwStrobe}, 8'd0);
        end else begin
          e = cmdQ.pop_front();
          checkOutput("cw_strobe", {1'b0, cwStrobe}, {1'b0, e.strobe});
          checkCycle("strobe_latency", cycleCnt, e.due);
          if (e.regA != R_NONE) checkOutput($sformatf("reg%0d", e.regA), getReg(e.regA), e.valA);
          if (e.regB != R_NONE) checkOutput($sformatf("reg%0d", e.regB), getReg(e.regB), e.valB);
        end
      end
      if (oe && !oePrev) begin
        if (readQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL unexpected_read: got data 0x%02h, no read expected", dataOut);
        end else begin
          checkOutput("read_data", dataOut, readQ.pop_front());
        end
      end
      oePrev = oe;
      if (readDone) begin
        if (doneQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL unexpected_read_done: got pulse at cycle %0d, none expected", cycleCnt);
        end else begin
          checkCycle("read_done_latency", cycleCnt, doneQ.pop_front());
        end
      end
    end
  end

  // Directed stimulus sequence.
  initial begin
    rst_bar  = 1'b0;
    CS_bar   = 1'b1;
    RD_bar   = 1'b1;
    WR_bar   = 1'b1;
    A0       = 1'b0;
    dataIn   = 8'h00;
    irrIn    = 8'h3C;
    isrIn    = 8'h81;
    pollWord = 8'h83;
    waitCycles(3);
    checkOutput("reset_imr", imr, 8'hFF);
    checkOutput("reset_init_done", {7'd0, initDone}, 8'd0);
    checkOutput("reset_icw1", icw1, 8'h00);
    checkOutput("reset_strobe", {1'b0, cwStrobe}, 8'd0);
    rst_bar = 1'b1;
    waitCycles(2);

    applyRead(1'b1, 8'hFF);
    applyStimulus(1'b1, 8'h55, 0, 7'd0, R_NONE, 8'd0, R_NONE, 8'd0);
    checkOutput("idle_imr", imr, 8'hFF);
    checkOutput("idle_init_done", {7'd0, initDone}, 8'd0);

    // Single mode, no ICW4.
    applyStimulus(1'b0, 8'h12, 0, 7'h01, R_ICW1, 8'h12, R_IMR, 8'h00);
    applyStimulus(1'b1, 8'h40, 0, 7'h02, R_ICW2, 8'h40, R_INIT, 8'h01);
    applyStimulus(1'b1, 8'hA5, 0, 7'h10, R_IMR, 8'hA5, R_NONE, 8'd0);
    applyRead(1'b1, 8'hA5);

    // Cascade with ICW4, plus an ignored write in WAIT_ICW3.
    applyStimulus(1'b0, 8'h11, 0, 7'h01, R_ICW1, 8'h11, R_INIT, 8'h00);
    applyStimulus(1'b1, 8'h08, 0, 7'h02, R_ICW2, 8'h08, R_INIT, 8'h00);
    applyStimulus(1'b0, 8'h20, 0, 7'd0, R_NONE, 8'd0, R_NONE, 8'd0);
    applyStimulus(1'b1, 8'h04, 0, 7'h04, R_ICW3, 8'h04, R_INIT, 8'h00);
    applyStimulus(1'b1, 8'h01, 0, 7'h08, R_ICW4, 8'h01, R_INIT, 8'h01);

    // OCW3 read-select and special mask mode; OCW2 with CS_bar rising first.
    applyStimulus(1'b0, 8'h0B, 0, 7'h40, R_RDSEL, 8'h01, R_SMM, 8'h00);
    applyRead(1'b0, 8'h81);
    applyStimulus(1'b0, 8'h68, 0, 7'h40, R_SMM, 8'h01, R_RDSEL, 8'h01);
    applyStimulus(1'b0, 8'h20, 1, 7'h20, R_OCW2, 8'h20, R_NONE, 8'd0);

    // Poll: select IRR, issue poll, read poll word, then IRR again.
    applyStimulus(1'b0, 8'h0A, 0, 7'h40, R_RDSEL, 8'h00, R_POLL, 8'h00);
    applyStimulus(1'b0, 8'h0C, 0, 7'h40, R_POLL, 8'h01, R_NONE, 8'd0);
    applyRead(1'b0, 8'h83);
    checkOutput("poll_cleared", {7'd0, poll}, 8'd0);
    applyRead(1'b0, 8'h3C);

    // RD_bar and WR_bar both low: bus stays disabled, write still lands.
    applyStimulus(1'b1, 8'h5A, 2, 7'h10, R_IMR, 8'h5A, R_NONE, 8'd0);

    // ICW1 from READY restarts the sequence.
    applyStimulus(1'b0, 8'h13, 0, 7'h01, R_IMR, 8'h00, R_INIT, 8'h00);
    checkOutput("restart_ocw2", ocw2, 8'h00);
    checkOutput("restart_smm", {7'd0, smm}, 8'd0);

    // Reset in WAIT_ICW3, in the middle of an ICW3 write.
    applyStimulus(1'b0, 8'h11, 0, 7'h01, R_ICW1, 8'h11, R_NONE, 8'd0);
    applyStimulus(1'b1, 8'h08, 0, 7'h02, R_ICW2, 8'h08, R_INIT, 8'h00);
    A0     = 1'b1;
    dataIn = 8'h04;
    CS_bar = 1'b0;
    WR_bar = 1'b0;
    waitCycles(2);
    rst_bar = 1'b0;
    waitCycles(1);
    checkOutput("midreset_imr", imr, 8'hFF);
    checkOutput("midreset_icw2", icw2, 8'h00);
    checkOutput("midreset_init_done", {7'd0, initDone}, 8'd0);
    rst_bar = 1'b1;
    waitCycles(2);
    WR_bar = 1'b1;
    CS_bar = 1'b1;
    waitCycles(6);
    checkOutput("midreset_icw3", icw3, 8'h00);

    waitCycles(4);
    checkCycle("cmd_queue_drained", cmdQ.size(), 0);
    checkCycle("read_queue_drained", readQ.size(), 0);
    checkCycle("done_queue_drained", doneQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
